radix2_divider: RTL

- Parametrised iterative radix-2 restoring integer divider.
- Accepts one dividend/divisor pair per operation over a valid/ready handshake.
- Computes signed or unsigned quotient and remainder, selected per operation.
- Detects divide-by-zero and signed overflow.
- Next-generation datapath divider: sits behind the issue logic as a multi-cycle execution unit, replacing the fixed-width divider FSM.

---
 rtl/divider_pkg.sv | 39 +++
 rtl/radix2_divider_clz.sv | 17 +
 rtl/radix2_divider.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/divider_pkg.sv
// Shared types and constants for the radix-2 restoring divider.
// Optional leading-zero pre-normalisation is enabled with RADIX2_DIVIDER_NORMALIZE_EN.
package divider_pkg;

   // Control states; SHIFT_COMPUTE is only entered when normalisation is built in.
   typedef enum logic [3:0] {
      RESET          = 4'd0,
      READ           = 4'd1,
      CHECK          = 4'd2,
      ERROR_ST       = 4'd3,
      PREP_INPUT     = 4'd4,
      INIT           = 4'd5,
      SHIFT_COMPUTE  = 4'd6,
      DIVIDE_COMPUTE = 4'd7,
      PREP_OUTPUT    = 4'd8,
      DONE           = 4'd9,
      STATEX         = 4'd10
   } state_struct;

   // Error results at the maximum legal width; the top slices them down to WIDTH.
   localparam logic [63:0] ERR_ONES  = '1;                      // divide-by-zero quotient
   localparam logic [63:0] ERR_MIN64 = 64'h8000_0000_0000_0000; // MIN pattern, MSB aligned

   // Leading zeros of the low 'width' bits of value (returns width for a zero value).
   function automatic int clz(input logic [63:0] value, input int width);
      int   n;
      logic found;
      n     = 0;
      found = 1'b0;
      for (int i = 63; i >= 0; i--) begin
         if (i < width && !found) begin
            if (value[i]) found = 1'b1;
            else          n     = n + 1;
         end
      end
      return n;
   endfunction

endpackage

// File: rtl/radix2_divider_clz.sv
// Single-cycle leading-zero counter for the divider's normalisation step.
module radix2_divider_clz
   import divider_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] value,
   output logic [CW-1:0]    count
);

   // Purely combinational priority scan from the MSB.
   always_comb begin
      count = CW'(clz(64'(value), WIDTH));
   end

endmodule

// File: rtl/radix2_divider.sv
// Iterative radix-2 restoring divider, signed/unsigned per operation,
// with divide-by-zero and signed-overflow detection.
// Define RADIX2_DIVIDER_NORMALIZE_EN to skip leading-zero iterations.
module radix2_divider
   import divider_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             is_signed,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             overflow
);

   localparam int             CW   = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] ONES = ERR_ONES[WIDTH-1:0];
   localparam logic [WIDTH-1:0] MINV = ERR_MIN64[63 -: WIDTH];

   state_struct state, nxt;

   logic [WIDTH-1:0] dvd;     // dividend, later its magnitude
   logic [WIDTH-1:0] dvs;     // divisor, later its magnitude
   logic             sgn;     // operation is signed
   logic             sign_q;  // negate quotient at the end
   logic             sign_r;  // negate remainder at the end
   logic [WIDTH-1:0] pr;      // partial remainder; the shifted trial carries the extra bit
   logic [WIDTH-1:0] qr;      // quotient register, starts as |dividend|
   logic [CW-1:0]    cnt;     // iterations left
   logic [WIDTH:0]   trial;   // (pr:qr << 1) upper half minus |divisor|

   assign trial     = {pr, qr[WIDTH-1]} - {1'b0, dvs};
   assign in_ready  = (state == READ);
   assign out_valid = (state == DONE);

`ifdef RADIX2_DIVIDER_NORMALIZE_EN
   logic [CW-1:0] lz;

   radix2_divider_clz #(.WIDTH(WIDTH), .CW(CW)) u_clz (
      .value (qr),
      .count (lz)
   );
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= RESET;
      else     state <= nxt;
   end

   // Next-state decode.
   always_comb begin
      nxt = state;
      case (state)
         RESET:      nxt = READ;
         READ:       if (in_valid) nxt = CHECK;
         CHECK: begin
            if (dvs == '0 || (sgn && dvd == MINV && dvs == ONES)) nxt = ERROR_ST;
            else                                                  nxt = PREP_INPUT;
         end
         ERROR_ST:   nxt = DONE;
         PREP_INPUT: nxt = INIT;
`ifdef RADIX2_DIVIDER_NORMALIZE_EN
         INIT:          nxt = SHIFT_COMPUTE;
         SHIFT_COMPUTE: nxt = (qr == '0) ? PREP_OUTPUT : DIVIDE_COMPUTE;
`else
         INIT:          nxt = DIVIDE_COMPUTE;
`endif
         DIVIDE_COMPUTE: if (cnt == CW'(1)) nxt = PREP_OUTPUT;
         PREP_OUTPUT:    nxt = DONE;
         DONE:           if (out_ready) nxt = READ;
         default:        nxt = RESET;
      endcase
   end

   // Datapath and result registers; results hold between operations.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dvd         <= '0;
         dvs         <= '0;
         sgn         <= 1'b0;
         sign_q      <= 1'b0;
         sign_r      <= 1'b0;
         pr          <= '0;
         qr          <= '0;
         cnt         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         case (state)
            READ: begin
               if (in_valid) begin
                  dvd <= dividend;
                  dvs <= divisor;
                  sgn <= is_signed;
               end
            end
            ERROR_ST: begin
               if (dvs == '0) begin
                  quotient    <= ONES;
                  remainder   <= dvd;
                  div_by_zero <= 1'b1;
               end else begin
                  quotient  <= MINV;
                  remainder <= '0;
                  overflow  <= 1'b1;
               end
            end
            PREP_INPUT: begin
               sign_q <= sgn & (dvd[WIDTH-1] ^ dvs[WIDTH-1]);
               sign_r <= sgn & dvd[WIDTH-1];
               if (sgn && dvd[WIDTH-1]) dvd <= -dvd;
               if (sgn && dvs[WIDTH-1]) dvs <= -dvs;
            end
            INIT: begin
               pr  <= '0;
               qr  <= dvd;
               cnt <= CW'(WIDTH);
            end
`ifdef RADIX2_DIVIDER_NORMALIZE_EN
            SHIFT_COMPUTE: begin
               // Leading zeros would only shift zeros into pr; skip them.
               qr  <= qr << lz;
               cnt <= CW'(WIDTH) - lz;
            end
`endif
            DIVIDE_COMPUTE: begin
               if (!trial[WIDTH]) begin
                  pr <= trial[WIDTH-1:0];
                  qr <= {qr[WIDTH-2:0], 1'b1};
               end else begin
                  pr <= {pr[WIDTH-2:0], qr[WIDTH-1]};
                  qr <= {qr[WIDTH-2:0], 1'b0};
               end
               cnt <= cnt - CW'(1);
            end
            PREP_OUTPUT: begin
               quotient  <= sign_q ? -qr : qr;
               remainder <= sign_r ? -pr : pr;
            end
            DONE: begin
               if (out_ready) begin
                  div_by_zero <= 1'b0;
                  overflow    <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
